// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: load/store request and response channels between core and data memory
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_read_data;
    logic        resp_error;
    modport master (
        output req_valid, req_write, req_address, req_write_data, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_read_data, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_address, req_write_data, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_read_data, resp_error
    );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-array data memory with RISC-V sized accesses and programmable wait states
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h10010000,
    parameter int unsigned WAIT_STATES  = 2
) (
    input logic clock,
    input logic reset,
    data_memory_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic wr_q, err_q;
    logic [2:0] f3_q, f3;
    logic [31:0] addr_q, data_q, rdata_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, enter_resp, wr, err, f3_ok, misaligned;
    logic [31:0] addr, wdata, offset, word, ld_data, wide_data;
    logic [3:0] be;
    logic [7:0] bsel;
    logic [15:0] hsel;
    logic [AW-1:0] idx;
    assign bus.req_ready = reset && state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_read_data = rdata_q;
    assign bus.resp_error = err_q;
    assign accept = bus.req_valid && bus.req_ready;
    assign enter_resp = state != RESP && state_n == RESP;
    // In IDLE the access is taken straight from the bus so a zero-wait request can complete on its accepting edge
    assign wr = state == IDLE ? bus.req_write : wr_q;
    assign addr = state == IDLE ? bus.req_address : addr_q;
    assign wdata = state == IDLE ? bus.req_write_data : data_q;
    assign f3 = state == IDLE ? bus.req_funct3 : f3_q;
    assign offset = addr - BASE_ADDRESS;
    assign idx = offset[AW+1:2];
    assign f3_ok = wr ? f3 <= 3'd2 : (f3 != 3'd3 && f3 < 3'd6);
    assign misaligned = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    assign err = !f3_ok || misaligned || offset >= 32'(DEPTH_WORDS * 4);
    assign word = mem[idx];
    assign bsel = word[{addr[1:0], 3'b000} +: 8];
    assign hsel = addr[1] ? word[31:16] : word[15:0];
    assign ld_data = f3 == 3'd0 ? {{24{bsel[7]}}, bsel} :
                     f3 == 3'd1 ? {{16{hsel[15]}}, hsel} :
                     f3 == 3'd4 ? {24'd0, bsel} :
                     f3 == 3'd5 ? {16'd0, hsel} : word;
    assign be = f3[1:0] == 2'd0 ? 4'b0001 << addr[1:0] :
                f3[1:0] == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wide_data = f3[1:0] == 2'd0 ? {4{wdata[7:0]}} :
                       f3[1:0] == 2'd1 ? {2{wdata[15:0]}} : wdata;
    // Next-state logic: accept in IDLE, count down wait states, hold RESP until the requester takes it
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = WAIT_STATES > 0 ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_n = RESP;
            RESP:    if (bus.resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // State, wait counter, request latches and the registered response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= accept ? 4'(WAIT_STATES) : (state == WAIT ? cnt - 4'd1 : cnt);
            if (accept) begin
                wr_q   <= bus.req_write;
                addr_q <= bus.req_address;
                data_q <= bus.req_write_data;
                f3_q   <= bus.req_funct3;
            end
            if (enter_resp) begin
                rdata_q <= (err || wr) ? 32'd0 : ld_data;
                err_q   <= err;
            end else if (state == RESP && bus.resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end
    // Store commit on the edge entering RESP; only the addressed byte lanes change
    always_ff @(posedge clock) begin
        if (enter_resp && wr && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wide_data[8*i +: 8];
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of latency, sized accesses, errors, backpressure and reset
module tb_data_memory_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    data_memory_responder_if ifa ();
    data_memory_responder_if ifz ();
    data_memory_responder #(.WAIT_STATES(2)) dut2 (.clock(clock), .reset(reset), .bus(ifa));
    data_memory_responder #(.WAIT_STATES(0)) dutz (.clock(clock), .reset(reset), .bus(ifz));
    always #5 clock = ~clock;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       output logic [31:0] rd, output logic e, output int lat);
        int n;
        ifa.req_valid = 1'b1;
        ifa.req_write = w;
        ifa.req_address = a;
        ifa.req_write_data = d;
        ifa.req_funct3 = f;
        ifa.resp_ready = 1'b1;
        n = 0;
        while (!ifa.req_ready && n < 20) begin @(posedge clock); #1; n++; end
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        lat = 1;
        while (!ifa.resp_valid && lat < 30) begin @(posedge clock); #1; lat++; end
        rd = ifa.resp_read_data;
        e = ifa.resp_error;
        @(posedge clock); #1;
    endtask
    task automatic txn_z(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                         output logic [31:0] rd, output logic e, output int lat);
        int n;
        ifz.req_valid = 1'b1;
        ifz.req_write = w;
        ifz.req_address = a;
        ifz.req_write_data = d;
        ifz.req_funct3 = f;
        ifz.resp_ready = 1'b1;
        n = 0;
        while (!ifz.req_ready && n < 20) begin @(posedge clock); #1; n++; end
        @(posedge clock); #1;
        ifz.req_valid = 1'b0;
        lat = 1;
        while (!ifz.resp_valid && lat < 30) begin @(posedge clock); #1; lat++; end
        rd = ifz.resp_read_data;
        e = ifz.resp_error;
        @(posedge clock); #1;
    endtask
    task automatic test_reset;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b0 || ifa.resp_valid !== 1'b0 || ifa.resp_read_data !== 32'd0 || ifa.resp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: ready=%b valid=%b data=%h err=%b expected 0 0 00000000 0",
                     ifa.req_ready, ifa.resp_valid, ifa.resp_read_data, ifa.resp_error);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b1 || ifa.resp_valid !== 1'b0 || ifz.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b ready_z=%b expected 1 0 1",
                     ifa.req_ready, ifa.resp_valid, ifz.req_ready);
        end
    endtask
    task automatic test_basic;
        logic [31:0] rd;
        logic e;
        int lat;
        txn(1'b1, 32'h10010000, 32'hDEADBEEF, 3'd2, rd, e, lat);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL sw_basic: lat=%0d err=%b data=%h expected 3 0 00000000", lat, e, rd);
        end
        txn(1'b0, 32'h10010000, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_basic: lat=%0d err=%b data=%h expected 3 0 deadbeef", lat, e, rd);
        end
    endtask
    task automatic test_extension;
        logic [31:0] rd;
        logic e;
        int lat;
        logic [31:0] addrs [6] = '{32'h10010004, 32'h10010007, 32'h10010006, 32'h10010004, 32'h10010005, 32'h10010006};
        logic [2:0]  f3s   [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd4};
        logic [31:0] exps  [6] = '{32'hFFFFFFF3, 32'h00000080, 32'hFFFF8081, 32'h0000F2F3, 32'hFFFFFFF2, 32'h00000081};
        txn(1'b1, 32'h10010004, 32'h8081F2F3, 3'd2, rd, e, lat);
        for (int i = 0; i < 6; i++) begin
            txn(1'b0, addrs[i], 32'd0, f3s[i], rd, e, lat);
            checks++;
            if (rd !== exps[i] || e !== 1'b0) begin
                errors++;
                $display("FAIL extension_%0d: data=%h err=%b expected %h 0", i, rd, e, exps[i]);
            end
        end
    endtask
    task automatic test_partial;
        logic [31:0] rd;
        logic e;
        int lat;
        txn(1'b1, 32'h10010008, 32'h11223344, 3'd2, rd, e, lat);
        txn(1'b1, 32'h1001000A, 32'hFFFFFFAA, 3'd0, rd, e, lat);
        txn(1'b1, 32'h10010008, 32'h1234BEEF, 3'd1, rd, e, lat);
        txn(1'b0, 32'h10010008, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (rd !== 32'h11AABEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL partial_store: data=%h err=%b expected 11aabeef 0", rd, e);
        end
    endtask
    task automatic test_errors;
        logic [31:0] rd;
        logic e;
        int lat;
        logic        ws [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] as [7] = '{32'h10010002, 32'h10010001, 32'h10011000, 32'h1000FFFC, 32'h10010000, 32'h10010000, 32'h10010000};
        logic [2:0]  fs [7] = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd3, 3'd6, 3'd3};
        for (int i = 0; i < 7; i++) begin
            txn(ws[i], as[i], 32'h0000CAFE, fs[i], rd, e, lat);
            checks++;
            if (e !== 1'b1 || rd !== 32'd0) begin
                errors++;
                $display("FAIL error_%0d: err=%b data=%h expected 1 00000000", i, e, rd);
            end
        end
        txn(1'b0, 32'h10010000, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL error_no_write: data=%h err=%b expected deadbeef 0", rd, e);
        end
        txn(1'b1, 32'h10010FFC, 32'h0BADF00D, 3'd2, rd, e, lat);
        txn(1'b0, 32'h10010FFC, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (rd !== 32'h0BADF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL last_word: data=%h err=%b expected 0badf00d 0", rd, e);
        end
    endtask
    task automatic test_backpressure;
        int n;
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b0;
        ifa.req_address = 32'h10010004;
        ifa.req_funct3 = 3'd2;
        ifa.resp_ready = 1'b0;
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'b1;
        ifa.req_address = 32'h10010000;
        ifa.req_write_data = 32'hFFFFFFFF;
        ifa.req_funct3 = 3'd0;
        n = 1;
        while (!ifa.resp_valid && n < 30) begin @(posedge clock); #1; n++; end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 3", n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifa.resp_valid !== 1'b1 || ifa.resp_read_data !== 32'h8081F2F3 || ifa.resp_error !== 1'b0 || ifa.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b data=%h err=%b ready=%b expected 1 8081f2f3 0 0",
                         i, ifa.resp_valid, ifa.resp_read_data, ifa.resp_error, ifa.req_ready);
            end
            @(posedge clock); #1;
        end
        ifa.resp_ready = 1'b1;
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b0;
        ifa.req_address = 32'h10010008;
        ifa.req_funct3 = 3'd2;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b0 || ifa.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_handshake: ready=%b valid=%b expected 0 1", ifa.req_ready, ifa.resp_valid);
        end
        @(posedge clock); #1;
        checks++;
        if (ifa.req_ready !== 1'b1 || ifa.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle_after: ready=%b valid=%b expected 1 0", ifa.req_ready, ifa.resp_valid);
        end
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        checks++;
        if (ifa.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_next: ready=%b expected 0", ifa.req_ready);
        end
        n = 1;
        while (!ifa.resp_valid && n < 30) begin @(posedge clock); #1; n++; end
        checks++;
        if (n !== 3 || ifa.resp_read_data !== 32'h11AABEEF) begin
            errors++;
            $display("FAIL bp_next_txn: lat=%0d data=%h expected 3 11aabeef", n, ifa.resp_read_data);
        end
        @(posedge clock); #1;
    endtask
    task automatic test_async_reset;
        logic [31:0] rd;
        logic e;
        int lat;
        int n;
        txn(1'b1, 32'h10010010, 32'h12345678, 3'd2, rd, e, lat);
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b1;
        ifa.req_address = 32'h10010010;
        ifa.req_write_data = 32'h55555555;
        ifa.req_funct3 = 3'd2;
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.req_ready !== 1'b0 || ifa.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_wait: ready=%b valid=%b expected 0 0", ifa.req_ready, ifa.resp_valid);
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        txn(1'b0, 32'h10010010, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_store: data=%h err=%b expected 12345678 0", rd, e);
        end
        ifa.req_valid = 1'b1;
        ifa.req_write = 1'b0;
        ifa.resp_ready = 1'b0;
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        n = 1;
        while (!ifa.resp_valid && n < 30) begin @(posedge clock); #1; n++; end
        checks++;
        if (ifa.resp_valid !== 1'b1 || ifa.resp_read_data !== 32'h12345678) begin
            errors++;
            $display("FAIL areset_pre: valid=%b data=%h expected 1 12345678", ifa.resp_valid, ifa.resp_read_data);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.resp_valid !== 1'b0 || ifa.resp_read_data !== 32'd0 || ifa.resp_error !== 1'b0 || ifa.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_resp: valid=%b data=%h err=%b ready=%b expected 0 00000000 0 0",
                     ifa.resp_valid, ifa.resp_read_data, ifa.resp_error, ifa.req_ready);
        end
        ifa.resp_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
    endtask
    task automatic test_zero_wait;
        logic [31:0] rd;
        logic e;
        int lat;
        txn_z(1'b1, 32'h10010020, 32'hA5A5A5A5, 3'd2, rd, e, lat);
        checks++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL zero_wait_sw: lat=%0d err=%b data=%h expected 1 0 00000000", lat, e, rd);
        end
        txn_z(1'b0, 32'h10010020, 32'd0, 3'd5, rd, e, lat);
        checks++;
        if (lat !== 1 || e !== 1'b0 || rd !== 32'h0000A5A5) begin
            errors++;
            $display("FAIL zero_wait_lhu: lat=%0d err=%b data=%h expected 1 0 0000a5a5", lat, e, rd);
        end
        txn_z(1'b0, 32'h10010021, 32'd0, 3'd2, rd, e, lat);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL zero_wait_err: lat=%0d err=%b data=%h expected 1 1 00000000", lat, e, rd);
        end
    endtask
    initial begin
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'b0;
        ifa.req_address = 32'd0;
        ifa.req_write_data = 32'd0;
        ifa.req_funct3 = 3'd0;
        ifa.resp_ready = 1'b1;
        ifz.req_valid = 1'b0;
        ifz.req_write = 1'b0;
        ifz.req_address = 32'd0;
        ifz.req_write_data = 32'd0;
        ifz.req_funct3 = 3'd0;
        ifz.resp_ready = 1'b1;
        test_reset;
        test_basic;
        test_extension;
        test_partial;
        test_errors;
        test_backpressure;
        test_async_reset;
        test_zero_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
